// File: rtl/reg_bank_arb.sv
// reg_bank_arb: two-requester write arbiter in front of a four-entry
// register bank. Each requester uses a four-phase REQ/ACK handshake; a
// handshake whose ACK stays up for TIMEOUT edges is aborted and flagged in
// the sticky ERR output.
// All state updates on the falling edge of CLK; RST is asynchronous, active-low.
// Optional feature macro: ARB_ROUND_ROBIN_EN. When it is defined, ties go
// to the requester not granted last. When it is undefined, A wins every tie.
module reg_bank_arb #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                REQ_A,
    input  logic [1:0]          ADDR_A,
    input  logic [DATA_W-1:0]   D_A,
    input  logic                REQ_B,
    input  logic [1:0]          ADDR_B,
    input  logic [DATA_W-1:0]   D_B,
    output logic                ACK_A,
    output logic                ACK_B,
    output logic [4*DATA_W-1:0] Q,
    output logic                BUSY,
    output logic                ERR
);

    localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_ACK} state_t;

    state_t            state_q, state_d;
    logic [1:0]        addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              win_b_q, win_b_d;
    logic [DATA_W-1:0] bank_q [4];
    logic [DATA_W-1:0] bank_d [4];
    logic              ack_a_q, ack_a_d;
    logic              ack_b_q, ack_b_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              elig_a_q, elig_a_d;
    logic              elig_b_q, elig_b_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic              last_b_q, last_b_d;
`endif

    logic              cand_a, cand_b, pick_b, win_req;
    logic [7:0]        cnt_inc;

    // Next-state computation: arbitration, write, handshake and timeout tracking
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        win_b_d  = win_b_q;
        bank_d   = bank_q;
        ack_a_d  = ack_a_q;
        ack_b_d  = ack_b_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        elig_a_d = elig_a_q;
        elig_b_d = elig_b_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_b_d = last_b_q;
`endif
        cnt_inc  = cnt_q + 8'd1;
        win_req  = win_b_q ? REQ_B : REQ_A;

        // A requester locked out by a timeout regains eligibility once it
        // has been seen with REQ low.
        if (!REQ_A) elig_a_d = 1'b1;
        if (!REQ_B) elig_b_d = 1'b1;

        cand_a = REQ_A && elig_a_q;
        cand_b = REQ_B && elig_b_q;
`ifdef ARB_ROUND_ROBIN_EN
        pick_b = cand_b && (!cand_a || !last_b_q);
`else
        pick_b = cand_b && !cand_a;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cand_a || cand_b) begin
                    state_d = ST_WRITE;
                    win_b_d = pick_b;
                    addr_d  = pick_b ? ADDR_B : ADDR_A;
                    data_d  = pick_b ? D_B : D_A;
`ifdef ARB_ROUND_ROBIN_EN
                    last_b_d = pick_b;
`endif
                end
            end
            ST_WRITE: begin
                bank_d[addr_q] = data_q;
                state_d        = ST_ACK;
                cnt_d          = 8'd0;
                ack_a_d        = !win_b_q;
                ack_b_d        = win_b_q;
            end
            ST_ACK: begin
                if (!win_req) begin
                    ack_a_d = 1'b0;
                    ack_b_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (cnt_inc == TIMEOUT_C) begin
                    ack_a_d = 1'b0;
                    ack_b_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                    if (win_b_q) elig_b_d = 1'b0;
                    else         elig_a_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers, cleared immediately by RST low
    always_ff @(negedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            win_b_q  <= 1'b0;
            for (int i = 0; i < 4; i++) bank_q[i] <= '0;
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            elig_a_q <= 1'b1;
            elig_b_q <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            last_b_q <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            win_b_q  <= win_b_d;
            bank_q   <= bank_d;
            ack_a_q  <= ack_a_d;
            ack_b_q  <= ack_b_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            elig_a_q <= elig_a_d;
            elig_b_q <= elig_b_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_b_q <= last_b_d;
`endif
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_q
        assign Q[gi*DATA_W +: DATA_W] = bank_q[gi];
    end

    assign ACK_A = ack_a_q;
    assign ACK_B = ack_b_q;
    assign BUSY  = busy_q;
    assign ERR   = err_q;

endmodule

// File: tb/tb_reg_bank_arb.sv
// Directed testbench for reg_bank_arb (TIMEOUT=4). Expectations follow the
// ARB_ROUND_ROBIN_EN macro so the same bench covers both builds.
module tb_reg_bank_arb;

    logic        CLK, RST;
    logic        REQ_A, REQ_B;
    logic [1:0]  ADDR_A, ADDR_B;
    logic [7:0]  D_A, D_B;
    logic        ACK_A, ACK_B, BUSY, ERR;
    logic [31:0] Q;

    int n_tests = 0;
    int n_fail  = 0;

    reg_bank_arb #(.DATA_W(8), .TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_A(REQ_A), .ADDR_A(ADDR_A), .D_A(D_A),
        .REQ_B(REQ_B), .ADDR_B(ADDR_B), .D_B(D_B),
        .ACK_A(ACK_A), .ACK_B(ACK_B), .Q(Q), .BUSY(BUSY), .ERR(ERR)
    );

    initial CLK = 1'b1;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %h", tag, got);
        end
    endtask

    // advance past one falling (active) edge and settle
    task automatic tick();
        @(negedge CLK);
        #2;
    endtask

    logic exp_a;
    logic [31:0] exp_q;

    initial begin
        RST = 1'b0; REQ_A = 0; REQ_B = 0;
        ADDR_A = 0; ADDR_B = 0; D_A = 0; D_B = 0;
        tick();
        check("rst_q", Q, 32'h0);
        check("rst_ack", {30'd0, ACK_A, ACK_B}, 32'h0);
        check("rst_busy_err", {30'd0, BUSY, ERR}, 32'h0);
        RST = 1'b1;

        // basic write from A
        REQ_A = 1; ADDR_A = 2; D_A = 8'h5A;
        tick();
        check("a_grant_busy", {31'd0, BUSY}, 32'h1);
        check("a_grant_noack", {31'd0, ACK_A}, 32'h0);
        tick();
        check("a_write_q", Q, 32'h005A0000);
        check("a_write_ack", {30'd0, ACK_A, ACK_B}, 32'h2);
        REQ_A = 0;
        tick();
        check("a_release", {29'd0, ACK_A, ACK_B, BUSY}, 32'h0);

        // B write; bus changes after grant must not matter
        REQ_B = 1; ADDR_B = 1; D_B = 8'h11;
        tick();
        D_B = 8'hFF; ADDR_B = 3;
        tick();
        check("b_latched_q", Q, 32'h005A1100);
        check("b_write_ack", {30'd0, ACK_A, ACK_B}, 32'h1);
        REQ_B = 0;
        tick();
        check("b_release", {29'd0, ACK_A, ACK_B, BUSY}, 32'h0);

        // contention: both requesting, winner drops one edge after its ACK
        ADDR_A = 0; ADDR_B = 3;
        REQ_A = 1; REQ_B = 1;
        for (int r = 0; r < 4; r++) begin
            D_A = 8'h10 + 8'(r);
            D_B = 8'h20 + 8'(r);
`ifdef ARB_ROUND_ROBIN_EN
            exp_a = (r % 2 == 0);
`else
            exp_a = 1'b1;
`endif
            tick();
            tick();
            check($sformatf("tie%0d_acks", r), {30'd0, ACK_A, ACK_B}, {30'd0, exp_a, !exp_a});
            if (exp_a) REQ_A = 0; else REQ_B = 0;
            tick();
            check($sformatf("tie%0d_drop", r), {29'd0, ACK_A, ACK_B, BUSY}, 32'h0);
            REQ_A = 1; REQ_B = 1;
        end
        REQ_A = 0; REQ_B = 0;
`ifdef ARB_ROUND_ROBIN_EN
        exp_q = 32'h235A1112;
`else
        exp_q = 32'h005A1113;
`endif
        tick();
        check("tie_q", Q, exp_q);

        // timeout: A holds REQ high forever, B waits
        REQ_A = 1; ADDR_A = 1; D_A = 8'h77;
        tick();
        tick();
        check("to_ack_start", {30'd0, ACK_A, ERR}, 32'h2);
        REQ_B = 1; ADDR_B = 2; D_B = 8'hC3;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("to_hold%0d", k), {30'd0, ACK_A, ERR}, 32'h2);
        end
        tick();
        check("to_abort", {29'd0, ACK_A, ACK_B, ERR}, 32'h1);
        tick();
        check("to_b_grant", {31'd0, BUSY}, 32'h1);
        tick();
        check("to_b_ack", {29'd0, ACK_A, ACK_B, ERR}, 32'h3);
        REQ_B = 0;
        tick();
        check("to_b_drop", {30'd0, ACK_B, BUSY}, 32'h0);
        tick();
        check("to_a_locked", {30'd0, BUSY, ACK_A}, 32'h0);
        REQ_A = 0;
        tick();
        REQ_A = 1; ADDR_A = 0; D_A = 8'h99;
        tick();
        check("to_a_regrant", {31'd0, BUSY}, 32'h1);
        tick();
        check("to_a_ack_err", {30'd0, ACK_A, ERR}, 32'h3);
`ifdef ARB_ROUND_ROBIN_EN
        exp_q = 32'h23C37799;
`else
        exp_q = 32'h00C37799;
`endif
        check("to_q", Q, exp_q);
        REQ_A = 0;
        tick();

        // reset while a write is pending
        REQ_A = 1; ADDR_A = 3; D_A = 8'hA5;
        tick();
        check("mr_busy", {31'd0, BUSY}, 32'h1);
        RST = 0;
        #1;
        check("mr_q", Q, 32'h0);
        check("mr_flags", {28'd0, ACK_A, ACK_B, BUSY, ERR}, 32'h0);
        REQ_A = 0;
        #1 RST = 1;
        REQ_A = 1; ADDR_A = 0; D_A = 8'h3C;
        REQ_B = 1; ADDR_B = 1; D_B = 8'h4D;
        tick();
        tick();
        check("mr_tie_a", {30'd0, ACK_A, ACK_B}, 32'h2);
        check("mr_q_a", Q, 32'h0000003C);
        REQ_A = 0;
        tick();
        check("mr_a_drop", {31'd0, ACK_A}, 32'h0);
        tick();
        tick();
        check("mr_b_ack", {30'd0, ACK_A, ACK_B}, 32'h1);
        check("mr_q_b", Q, 32'h00004D3C);
        REQ_B = 0;
        tick();
        check("mr_idle", {29'd0, ACK_B, BUSY, ERR}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
